// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller.
// Holds the FSM state enum, the opcode constants the controller recognises,
// the ALU operation codes, and the datapath mux-select encodings.
package pa_riscv;

    // Controller states; the reset state is S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } e_mcState;

    // State entered on reset. This is fixed and kept here only as documentation.
    localparam e_mcState RESET_STATE = S_FETCH;

    // Opcode field values (instruction bits 6:0).
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011;
    localparam logic [6:0] BTYPE = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;

    // ALU operation codes presented on o_aluLogicOperation.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;

    // Class of ALU operation the FSM asks the decoder for.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } e_aluOpClass;

    // Memory address select.
    typedef enum logic {
        ADR_PC     = 1'b0,
        ADR_RESULT = 1'b1
    } e_adrSrc;

    // ALU operand A select.
    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2
    } e_aluSrcA;

    // ALU operand B select.
    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } e_aluSrcB;

    // Register write-back / PC source select.
    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'd0,
        RES_MEMDATA   = 2'd1,
        RES_ALURESULT = 2'd2
    } e_resultSrc;

    // BEQ is taken on a zero difference, BNE on a non-zero one; any other
    // branch funct3 is not supported and never redirects the PC.
    function automatic logic branchTaken(input logic [2:0] funct3, input logic zeroFlag);
        logic taken;
        taken = 1'b0;
        if (funct3 == 3'b000) begin
            taken = zeroFlag;
        end else if (funct3 == 3'b001) begin
            taken = ~zeroFlag;
        end
        return taken;
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// Combinational ALU decoder for the multi-cycle controller.
// Turns the FSM's operation class plus the instruction's funct fields into
// the ALU operation code. Only R-type instructions (opcode bit 5 set) use
// funct7 bit 5 to select SUB; shifts use it for both R and I forms.
module alu_decoder
    import pa_riscv::*;
(
    input  logic [1:0] i_aluOp,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_opBit5,
    output logic [3:0] o_aluLogicOperation
);

    // Select the ALU operation; anything unsupported falls back to ADD.
    always_comb begin
        o_aluLogicOperation = ALU_ADD;
        case (i_aluOp)
            ALUOP_SUB: begin
                o_aluLogicOperation = ALU_SUB;
            end
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: o_aluLogicOperation = (i_opBit5 && i_funct7bit5) ? ALU_SUB : ALU_ADD;
                    3'b001: o_aluLogicOperation = ALU_SLL;
                    3'b010: o_aluLogicOperation = ALU_SLT;
                    3'b100: o_aluLogicOperation = ALU_XOR;
                    3'b101: o_aluLogicOperation = i_funct7bit5 ? ALU_SRA : ALU_SRL;
                    3'b110: o_aluLogicOperation = ALU_OR;
                    3'b111: o_aluLogicOperation = ALU_AND;
                    default: o_aluLogicOperation = ALU_ADD;
                endcase
            end
            default: begin
                o_aluLogicOperation = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core.
// One unified memory and one ALU are shared between fetch, PC increment,
// address generation and execute; this block walks each instruction through
// those shared resources and drives every mux select and write enable.
// Optional build macro MULTI_CYCLE_MEM_READY_EN adds i_memReady so memory
// accesses (FETCH, MEMREAD, MEMWRITE) can stretch over several cycles;
// without it memory answers in a single cycle.
module multi_cycle_controller
    import pa_riscv::*;
(
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
`ifdef MULTI_CYCLE_MEM_READY_EN
    input  logic       i_memReady,
`endif
    output logic       o_pcWriteEn,
    output logic       o_adrSrc,
    output logic       o_memWriteEn,
    output logic       o_irWriteEn,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic       o_regWriteEn,
    output logic [3:0] o_aluLogicOperation,
    output logic       o_instrRetired,
    output logic       o_illegalInstr
);

    e_mcState    state_q;
    e_mcState    state_d;
    e_aluOpClass aluOpClass;
    logic        memReady;

`ifdef MULTI_CYCLE_MEM_READY_EN
    assign memReady = i_memReady;
`else
    assign memReady = 1'b1;
`endif

    // State register; reset always lands in FETCH.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls. Everything defaults to 0 so unused
    // selects are never X, and reset holds every output at 0 so no write
    // enable can fire in a reset cycle even mid-instruction.
    always_comb begin
        state_d        = state_q;
        o_pcWriteEn    = 1'b0;
        o_adrSrc       = ADR_PC;
        o_memWriteEn   = 1'b0;
        o_irWriteEn    = 1'b0;
        o_resultSrc    = RES_ALUOUT;
        o_aluSrcA      = SRCA_PC;
        o_aluSrcB      = SRCB_RS2;
        o_regWriteEn   = 1'b0;
        o_instrRetired = 1'b0;
        o_illegalInstr = 1'b0;
        aluOpClass     = ALUOP_ADD;

        if (!i_srst) begin
            case (state_q)
                S_FETCH: begin
                    // Read instruction at PC while the ALU forms PC+4.
                    o_adrSrc    = ADR_PC;
                    o_irWriteEn = memReady;
                    o_aluSrcA   = SRCA_PC;
                    o_aluSrcB   = SRCB_FOUR;
                    o_resultSrc = RES_ALURESULT;
                    o_pcWriteEn = memReady;
                    if (memReady) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // ALU precomputes oldPC+imm for a possible branch/JAL.
                    o_aluSrcA = SRCA_OLDPC;
                    o_aluSrcB = SRCB_IMM;
                    case (i_operand)
                        LW, SW: state_d = S_MEMADR;
                        RTYPE:  state_d = S_EXECR;
                        ITYPE:  state_d = S_EXECI;
                        BTYPE:  state_d = S_BRANCH;
                        JAL:    state_d = S_JAL;
                        default: begin
                            o_illegalInstr = 1'b1;
                            state_d        = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    o_aluSrcA = SRCA_RS1;
                    o_aluSrcB = SRCB_IMM;
                    state_d   = (i_operand == SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    o_adrSrc = ADR_RESULT;
                    if (memReady) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    o_resultSrc    = RES_MEMDATA;
                    o_regWriteEn   = 1'b1;
                    o_instrRetired = 1'b1;
                    state_d        = S_FETCH;
                end
                S_MEMWRITE: begin
                    // The store only counts once memory has accepted it.
                    o_adrSrc       = ADR_RESULT;
                    o_memWriteEn   = memReady;
                    o_instrRetired = memReady;
                    if (memReady) begin
                        state_d = S_FETCH;
                    end
                end
                S_EXECR: begin
                    o_aluSrcA  = SRCA_RS1;
                    o_aluSrcB  = SRCB_RS2;
                    aluOpClass = ALUOP_FUNCT;
                    state_d    = S_ALUWB;
                end
                S_EXECI: begin
                    o_aluSrcA  = SRCA_RS1;
                    o_aluSrcB  = SRCB_IMM;
                    aluOpClass = ALUOP_FUNCT;
                    state_d    = S_ALUWB;
                end
                S_ALUWB: begin
                    o_resultSrc    = RES_ALUOUT;
                    o_regWriteEn   = 1'b1;
                    o_instrRetired = 1'b1;
                    state_d        = S_FETCH;
                end
                S_BRANCH: begin
                    // Compare rs1-rs2 while the target from DECODE sits in ALU out.
                    o_aluSrcA      = SRCA_RS1;
                    o_aluSrcB      = SRCB_RS2;
                    aluOpClass     = ALUOP_SUB;
                    o_resultSrc    = RES_ALUOUT;
                    o_pcWriteEn    = branchTaken(i_funct3, i_zeroFlag);
                    o_instrRetired = 1'b1;
                    state_d        = S_FETCH;
                end
                S_JAL: begin
                    // Jump to the DECODE target while forming the link value oldPC+4.
                    o_aluSrcA   = SRCA_OLDPC;
                    o_aluSrcB   = SRCB_FOUR;
                    o_resultSrc = RES_ALUOUT;
                    o_pcWriteEn = 1'b1;
                    state_d     = S_ALUWB;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    alu_decoder u_aluDecoder (
        .i_aluOp             (aluOpClass),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .i_opBit5            (i_operand[5]),
        .o_aluLogicOperation (o_aluLogicOperation)
    );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller.
// Stimulus issues whole instructions and pushes a per-instruction summary
// predicted from the instruction set rules; a monitor gathers what the DUT
// did between instruction boundaries and compares against that summary.
module tb_multi_cycle_controller;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SLT = 5;
    localparam int OP_SLL = 6;
    localparam int OP_SRL = 7;
    localparam int OP_SRA = 8;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_B   = 7'b1100011;
    localparam logic [6:0] C_JAL = 7'b1101111;

`ifdef MULTI_CYCLE_MEM_READY_EN
    localparam bit READY_PORT = 1'b1;
`else
    localparam bit READY_PORT = 1'b0;
`endif

    logic       i_clk;
    logic       i_srst;
    logic [6:0] i_operand;
    logic [2:0] i_funct3;
    logic       i_funct7bit5;
    logic       i_zeroFlag;
    logic       i_memReady;
    logic       o_pcWriteEn;
    logic       o_adrSrc;
    logic       o_memWriteEn;
    logic       o_irWriteEn;
    logic [1:0] o_resultSrc;
    logic [1:0] o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic       o_regWriteEn;
    logic [3:0] o_aluLogicOperation;
    logic       o_instrRetired;
    logic       o_illegalInstr;

    logic [16:0] outVec;
    assign outVec = {o_pcWriteEn, o_adrSrc, o_memWriteEn, o_irWriteEn, o_resultSrc,
                     o_aluSrcA, o_aluSrcB, o_regWriteEn, o_aluLogicOperation,
                     o_instrRetired, o_illegalInstr};

    multi_cycle_controller dut (
        .i_clk               (i_clk),
        .i_srst              (i_srst),
        .i_operand           (i_operand),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .i_zeroFlag          (i_zeroFlag),
`ifdef MULTI_CYCLE_MEM_READY_EN
        .i_memReady          (i_memReady),
`endif
        .o_pcWriteEn         (o_pcWriteEn),
        .o_adrSrc            (o_adrSrc),
        .o_memWriteEn        (o_memWriteEn),
        .o_irWriteEn         (o_irWriteEn),
        .o_resultSrc         (o_resultSrc),
        .o_aluSrcA           (o_aluSrcA),
        .o_aluSrcB           (o_aluSrcB),
        .o_regWriteEn        (o_regWriteEn),
        .o_aluLogicOperation (o_aluLogicOperation),
        .o_instrRetired      (o_instrRetired),
        .o_illegalInstr      (o_illegalInstr)
    );

    // Expected behaviour of one instruction, in counts of observable events.
    typedef struct packed {
        int cycles;
        int nIr;
        int nPc;
        int nReg;
        int nMem;
        int nMemAdr;
        int nRet;
        int nIll;
        int nRs1;
        int rs1Op;
        int rs1SrcB;
        int regSrc;
        int nJalPc;
        int nFetchSig;
        int nDecodeSig;
    } exp_t;

    exp_t expQ[$];
    int   total;
    int   bad;

    // Monitor accumulators for the instruction in flight.
    int mCyc, mIr, mPc, mReg, mMem, mMemAdr, mRs1, mRs1Op, mRs1SrcB, mRegSrc;
    int mJalPc, mFetchSig, mDecodeSig;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit isLegal(input logic [6:0] op);
        return (op == C_LW) || (op == C_SW) || (op == C_R) || (op == C_I) ||
               (op == C_B) || (op == C_JAL);
    endfunction

    // ALU operation for R/I instructions from the funct fields.
    function automatic int funcOp(input logic [2:0] f3, input logic f7, input bit isR);
        case (f3)
            3'd0: return (isR && f7) ? OP_SUB : OP_ADD;
            3'd1: return OP_SLL;
            3'd2: return OP_SLT;
            3'd4: return OP_XOR;
            3'd5: return f7 ? OP_SRA : OP_SRL;
            3'd6: return OP_OR;
            3'd7: return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction

    // Reference model: what one instruction should do, given how many cycles
    // its fetch (fLen) and data access (mLen) take.
    function automatic exp_t predict(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic zero, input int fLen, input int mLen);
        exp_t e;
        bit   taken;
        e = '0;
        e.nIr = 1;
        e.nPc = 1;
        e.nFetchSig = 1;
        e.nDecodeSig = 1;
        taken = ((f3 == 3'd0) && zero) || ((f3 == 3'd1) && !zero);
        if (op == C_LW) begin
            e.cycles = fLen + 2 + mLen + 1;
            e.nReg = 1; e.regSrc = 1; e.nRet = 1;
            e.nRs1 = 1; e.rs1Op = OP_ADD; e.rs1SrcB = 1;
        end else if (op == C_SW) begin
            e.cycles = fLen + 2 + mLen;
            e.nMem = 1; e.nMemAdr = 1; e.nRet = 1;
            e.nRs1 = 1; e.rs1Op = OP_ADD; e.rs1SrcB = 1;
        end else if (op == C_R) begin
            e.cycles = fLen + 3;
            e.nReg = 1; e.regSrc = 0; e.nRet = 1;
            e.nRs1 = 1; e.rs1Op = funcOp(f3, f7, 1'b1); e.rs1SrcB = 0;
        end else if (op == C_I) begin
            e.cycles = fLen + 3;
            e.nReg = 1; e.regSrc = 0; e.nRet = 1;
            e.nRs1 = 1; e.rs1Op = funcOp(f3, f7, 1'b0); e.rs1SrcB = 1;
        end else if (op == C_B) begin
            e.cycles = fLen + 2;
            e.nRet = 1; e.nPc = taken ? 2 : 1;
            e.nRs1 = 1; e.rs1Op = OP_SUB; e.rs1SrcB = 0;
        end else if (op == C_JAL) begin
            e.cycles = fLen + 3;
            e.nReg = 1; e.regSrc = 0; e.nRet = 1; e.nPc = 2; e.nJalPc = 1;
        end else begin
            e.cycles = fLen + 1;
            e.nIll = 1;
        end
        return e;
    endfunction

    function automatic void clearMon();
        mCyc = 0; mIr = 0; mPc = 0; mReg = 0; mMem = 0; mMemAdr = 0; mRs1 = 0;
        mRs1Op = 0; mRs1SrcB = 0; mRegSrc = 0; mJalPc = 0; mFetchSig = 0; mDecodeSig = 0;
    endfunction

    // Monitor: gather events each cycle, compare at every instruction boundary.
    initial begin : monitor
        exp_t e;
        clearMon();
        forever begin
            @(negedge i_clk);
            if (i_srst) begin
                clearMon();
            end else begin
                mCyc++;
                mIr += int'(o_irWriteEn);
                mPc += int'(o_pcWriteEn);
                if (o_aluSrcA == 2'd2) begin
                    mRs1++;
                    mRs1Op = int'(o_aluLogicOperation);
                    mRs1SrcB = int'(o_aluSrcB);
                end
                if (o_regWriteEn) begin
                    mReg++;
                    mRegSrc = int'(o_resultSrc);
                end
                if (o_memWriteEn) begin
                    mMem++;
                    if (o_adrSrc) mMemAdr++;
                end
                if (o_pcWriteEn && o_aluSrcA == 2'd1 && o_aluSrcB == 2'd2) mJalPc++;
                if (o_irWriteEn && o_pcWriteEn && !o_adrSrc && o_aluSrcA == 2'd0 &&
                    o_aluSrcB == 2'd2 && o_resultSrc == 2'd2 && o_aluLogicOperation == 4'd0)
                    mFetchSig++;
                if (o_aluSrcA == 2'd1 && o_aluSrcB == 2'd1 && !o_pcWriteEn && !o_memWriteEn &&
                    !o_irWriteEn && !o_regWriteEn)
                    mDecodeSig++;
                if (o_instrRetired || o_illegalInstr) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected boundary", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("latency", mCyc, e.cycles);
                        checkOutput("irWrite count", mIr, e.nIr);
                        checkOutput("pcWrite count", mPc, e.nPc);
                        checkOutput("regWrite count", mReg, e.nReg);
                        checkOutput("memWrite count", mMem, e.nMem);
                        checkOutput("memWrite at aluout adr", mMemAdr, e.nMemAdr);
                        checkOutput("retired", int'(o_instrRetired), e.nRet);
                        checkOutput("illegal", int'(o_illegalInstr), e.nIll);
                        checkOutput("rs1 cycles", mRs1, e.nRs1);
                        checkOutput("jal pc write", mJalPc, e.nJalPc);
                        checkOutput("fetch signature", mFetchSig, e.nFetchSig);
                        checkOutput("decode signature", mDecodeSig, e.nDecodeSig);
                        if (e.nRs1 > 0) begin
                            checkOutput("alu op", mRs1Op, e.rs1Op);
                            checkOutput("srcB in exec", mRs1SrcB, e.rs1SrcB);
                        end
                        if (e.nReg > 0) checkOutput("resultSrc at regWrite", mRegSrc, e.regSrc);
                    end
                    clearMon();
                end else if (mCyc > 40) begin
                    checkOutput("boundary timeout", mCyc, 0);
                    clearMon();
                end
            end
        end
    end

    // Issue one instruction for as many cycles as the model says it takes.
    // wF/wM are memory wait cycles for fetch and data access when the ready
    // handshake exists. mode 1 adds cycle-exact checks for the first LW after
    // reset; mode 2 aborts the instruction with reset in its final cycle.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic zero, input int wF, input int wM, input int mode);
        exp_t e;
        int   fLen;
        int   mLen;
        int   memStart;
        bit   isMem;
        fLen = READY_PORT ? wF + 1 : 1;
        mLen = READY_PORT ? wM + 1 : 1;
        memStart = fLen + 2;
        isMem = (op == C_LW) || (op == C_SW);
        e = predict(op, f3, f7, zero, fLen, mLen);
        if (mode != 2) expQ.push_back(e);
        i_operand = op;
        i_funct3 = f3;
        i_funct7bit5 = f7;
        i_zeroFlag = zero;
        for (int c = 0; c < e.cycles; c++) begin
            if (c < fLen - 1) i_memReady = 1'b0;
            else if (c == fLen - 1) i_memReady = 1'b1;
            else if (isMem && c >= memStart && c < memStart + mLen - 1) i_memReady = 1'b0;
            else if (isMem && c == memStart + mLen - 1) i_memReady = 1'b1;
            else i_memReady = 1'($urandom);
            if (mode == 2 && c == e.cycles - 1) i_srst = 1'b1;
            @(negedge i_clk);
            if (mode == 1 && c == 0) begin
                checkOutput("first fetch irWriteEn", o_irWriteEn, 1);
                checkOutput("first fetch pcWriteEn", o_pcWriteEn, 1);
                checkOutput("first fetch aluSrcB", o_aluSrcB, 2);
            end
            if (mode == 1 && c == 1)
                checkOutput("decode enables", {o_pcWriteEn, o_memWriteEn, o_irWriteEn, o_regWriteEn}, 0);
            if (mode == 1 && c == e.cycles - 1) begin
                checkOutput("lw wb regWriteEn", o_regWriteEn, 1);
                checkOutput("lw wb resultSrc", o_resultSrc, 1);
            end
            if (mode == 2 && c == e.cycles - 1) checkOutput("mid-instr reset outputs", outVec, 0);
            @(posedge i_clk);
            #1;
            if (mode == 2 && c == e.cycles - 1) i_srst = 1'b0;
        end
    endtask

    task automatic randomInstr();
        logic [6:0] op;
        logic [2:0] f3;
        int         k;
        k = $urandom_range(0, 6);
        case (k)
            0: op = C_LW;
            1: op = C_SW;
            2: op = C_R;
            3: op = C_I;
            4: op = C_B;
            5: op = C_JAL;
            default: begin
                op = 7'($urandom_range(0, 127));
                while (isLegal(op)) op = 7'($urandom_range(0, 127));
            end
        endcase
        f3 = (op == C_B) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        applyStimulus(op, f3, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        i_srst = 1'b1;
        i_operand = C_B;
        i_funct3 = 3'd0;
        i_funct7bit5 = 1'b0;
        i_zeroFlag = 1'b1;
        i_memReady = 1'b1;
        repeat (2) begin
            @(negedge i_clk);
            checkOutput("outputs in reset", outVec, 0);
        end
        @(posedge i_clk);
        #1;
        i_srst = 1'b0;

        applyStimulus(C_LW, 3'd2, 1'b0, 1'b0, 0, 0, 1);
        applyStimulus(C_R, 3'd0, 1'b1, 1'b0, 0, 0, 0);
        applyStimulus(C_B, 3'd0, 1'b0, 1'b1, 0, 0, 0);
        applyStimulus(C_B, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(C_B, 3'd1, 1'b0, 1'b1, 0, 0, 0);
        applyStimulus(C_B, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(C_SW, 3'd2, 1'b0, 1'b0, 0, 3, 0);
        applyStimulus(C_JAL, 3'd0, 1'b0, 1'b0, 1, 0, 0);
        applyStimulus(C_I, 3'd5, 1'b1, 1'b0, 0, 0, 0);
        applyStimulus(C_I, 3'd0, 1'b1, 1'b0, 0, 0, 0);
        applyStimulus(C_R, 3'd3, 1'b0, 1'b0, 0, 0, 0);

        for (int n = 0; n < 60; n++) randomInstr();

        applyStimulus(C_LW, 3'd2, 1'b0, 1'b0, 0, 0, 2);
        for (int n = 0; n < 6; n++) randomInstr();

        i_operand = C_LW;
        i_memReady = 1'b0;
        @(negedge i_clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
